spi_frame_rx: RTL and testbench

Downstream consumer of spi_parity_odd_fsm inside the SPI slave receive path. Shares the FSM's cs/sample/in inputs and takes its parity_bit output. Deserialises one frame of DATA_W data bits followed by one transmitted parity bit. Presents the word with a one-cycle valid strobe, a parity-error flag (transmitted bit vs FSM-computed odd parity) and a framing-error strobe for truncated frames.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_shift_in.sv | 26 ++
 rtl/spi_frame_rx.sv | 79 +++++++
 tb/tb_spi_frame_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI receive-path definitions: state encoding and the default word width.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_shift_in.sv
// Serial-in/parallel-out register with shift enable and clear.
// SPI_FRAME_RX_LSB_FIRST_EN selects LSB-first shifting (first bit ends in q[0]).
module spi_shift_in #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              in,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
`ifdef SPI_FRAME_RX_LSB_FIRST_EN
            q <= {in, q[DATA_W-1:1]};
`else
            q <= {q[DATA_W-2:0], in};
`endif
        end
    end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame deserialiser: DATA_W data bits plus one odd-parity bit, checked
// against the parity FSM. Bit order set by SPI_FRAME_RX_LSB_FIRST_EN (default MSB first).
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              sample,
    input  logic              in,
    input  logic              parity_bit,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] shreg;
    logic              shift_en;

    // Only data bits enter the register; the parity bit and post-frame samples do not.
    assign shift_en = !cs && sample && (state == IDLE || state == DATA);

    spi_shift_in #(.DATA_W(DATA_W)) u_shift (
        .clk   (clk),
        .reset (reset),
        .clr   (cs),
        .en    (shift_en),
        .in    (in),
        .q     (shreg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (cs) begin
                // Deselect aborts any frame; only a partially received one is an error.
                state     <= IDLE;
                count     <= '0;
                frame_err <= (state == DATA) || (state == PAR);
            end else if (sample) begin
                case (state)
                    IDLE: begin
                        count <= CNT_W'(1);
                        state <= (DATA_W == 1) ? PAR : DATA;
                    end
                    DATA: begin
                        count <= count + 1'b1;
                        if (count == LAST_DATA)
                            state <= PAR;
                    end
                    PAR: begin
                        data       <= shreg;
                        parity_err <= (in != parity_bit);
                        valid      <= 1'b1;
                        state      <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: queue-based frame model checked every cycle,
// a table of complete frames, hand-written corner sequences and random traffic.
module tb_spi_frame_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, cs, sample, in, parity_bit;
    logic [W-1:0] data;
    logic         valid, parity_err, frame_err;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic         q_bits[$];
    bit           done_m = 0;
    logic [W-1:0] ed = '0;
    logic         ep = 0, ev = 0, ef = 0;

    spi_frame_rx #(.DATA_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .sample     (sample),
        .in         (in),
        .parity_bit (parity_bit),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
`ifdef SPI_FRAME_RX_LSB_FIRST_EN
            w[i] = q_bits[i];
`else
            w[W-1-i] = q_bits[i];
`endif
        end
        return w;
    endfunction

    // One clock: drive inputs, advance the model, compare every output after the edge.
    task automatic cyc(input logic c, input logic s, input logic b, input logic r = 1'b0);
        logic x = 1'b0;
        foreach (q_bits[i]) x ^= q_bits[i];
        reset = r; cs = c; sample = s; in = b;
        parity_bit = ~x;
        ev = 0; ef = 0;
        if (r) begin
            q_bits.delete(); done_m = 0; ed = '0; ep = 0;
        end else if (c) begin
            ef = (q_bits.size() > 0) && !done_m;
            q_bits.delete(); done_m = 0;
        end else if (s && !done_m) begin
            if (q_bits.size() < W) q_bits.push_back(b);
            else begin
                ed = pack_bits(); ep = (b != ~x); ev = 1; done_m = 1;
            end
        end
        @(posedge clk); #1;
        chk("valid", 32'(valid), 32'(ev));
        chk("frame_err", 32'(frame_err), 32'(ef));
        chk("data", 32'(data), 32'(ed));
        chk("parity_err", 32'(parity_err), 32'(ep));
    endtask

    task automatic send_bits(input logic [W-1:0] word, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, word[W-1-i]);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic         pin;
        logic [W-1:0] exp_msb;
        logic [W-1:0] exp_lsb;
        logic         exp_pe;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [W-1:0] exp_d;
        tbl[0] = '{8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1};
        tbl[2] = '{8'h3C, 1'b1, 8'h3C, 8'h3C, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{8'h12, 1'b0, 8'h12, 8'h48, 1'b1};
        tbl[5] = '{8'h01, 1'b0, 8'h01, 8'h80, 1'b0};

        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);

        foreach (tbl[k]) begin
`ifdef SPI_FRAME_RX_LSB_FIRST_EN
            exp_d = tbl[k].exp_lsb;
`else
            exp_d = tbl[k].exp_msb;
`endif
            send_bits(tbl[k].word, W);
            cyc(1'b0, 1'b1, tbl[k].pin);
            chk("tbl_valid", 32'(valid), 32'h1);
            chk("tbl_data", 32'(data), 32'(exp_d));
            chk("tbl_perr", 32'(parity_err), 32'(tbl[k].exp_pe));
            cyc(1'b0, 1'b0, 1'b0);
            chk("tbl_valid_drop", 32'(valid), 32'h0);
            cyc(1'b1, 1'b0, 1'b0);
            chk("tbl_no_ferr", 32'(frame_err), 32'h0);
        end

        // truncated frame: frame_err pulse, data keeps the last word (0x01 / 0x80)
        cyc(1'b0, 1'b0, 1'b0);
        send_bits(8'hFF, 5);
        cyc(1'b1, 1'b0, 1'b0);
        chk("abort_ferr", 32'(frame_err), 32'h1);
        chk("abort_valid", 32'(valid), 32'h0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("abort_ferr_pulse", 32'(frame_err), 32'h0);

        // cs=1 with sample=1 is ignored, then 9 back-to-back samples of 0xFF + parity 1
        send_bits(8'hAA, 3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("cs_sample_ferr", 32'(frame_err), 32'h1);
        send_bits(8'hFF, W);
        cyc(1'b0, 1'b1, 1'b1);
        chk("ff_data", 32'(data), 32'hFF);
        chk("ff_perr", 32'(parity_err), 32'h0);

        // extra samples after the frame are ignored; closing cs is not a framing error
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'(i));
            chk("done_no_valid", 32'(valid), 32'h0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("done_no_ferr", 32'(frame_err), 32'h0);

        // reset mid-frame clears everything without any strobe
        send_bits(8'hF0, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_reset_data", 32'(data), 32'h0);
        chk("mid_reset_ferr", 32'(frame_err), 32'h0);
        send_bits(8'h01, W);
        cyc(1'b0, 1'b1, 1'b0);
`ifdef SPI_FRAME_RX_LSB_FIRST_EN
        chk("post_reset_data", 32'(data), 32'h80);
`else
        chk("post_reset_data", 32'(data), 32'h01);
`endif
        chk("post_reset_perr", 32'(parity_err), 32'h0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(19) == 0, $urandom_range(2) != 0,
                1'($urandom), $urandom_range(149) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
